// File: rtl/pc_unit.sv
// pc_unit: fetch PC sequencer with branch/jump/jr redirect, exception trap and masked level interrupt.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] id_pc_plus_4,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic        irq,
  output logic [31:0] PC,
  output logic        flush_IF,
  output logic        irq_ack,
  output logic [31:0] EPC
);
  logic [31:0] pc_q, pc_d, epc_q, epc_d, pc_plus_4;
  logic        irq_pending_q, irq_pending_d, irq_ack_q, irq_take, jr_go, jump_go;
  always_comb begin
    pc_plus_4     = pc_q + 32'd4;
    jr_go         = jr & ~stall;
    jump_go       = jump & ~stall;
    // kernel mode (PC[31]) masks the interrupt; any other redirect defers it
    irq_take      = irq_pending_q & ~pc_q[31] & ~stall & ~exception & ~branch_taken & ~jr & ~jump;
    pc_d          = exception    ? EXC_VEC :
                    branch_taken ? branch_target :
                    irq_take     ? IRQ_VEC :
                    jr_go        ? jr_target :
                    jump_go      ? {id_pc_plus_4[31:28], jump_index, 2'b00} :
                    stall        ? pc_q : pc_plus_4;
    epc_d         = exception ? id_pc_plus_4 - 32'd4 : irq_take ? pc_plus_4 : epc_q;
    irq_pending_d = ~irq_take & (irq_pending_q | irq);
    flush_IF      = ~reset & (exception | branch_taken | irq_take | jr_go | jump_go);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      epc_q         <= 32'd0;
      irq_pending_q <= 1'b0;
      irq_ack_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      irq_pending_q <= irq_pending_d;
      irq_ack_q     <= irq_take;
    end
  end
  assign PC      = pc_q;
  assign EPC     = epc_q;
  assign irq_ack = irq_ack_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus hand sequences for multi-cycle interrupt/stall/reset cases.
module tb_pc_unit;
  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr, exception, irq;
  logic [31:0] branch_target, id_pc_plus_4, jr_target;
  logic [25:0] jump_index;
  logic [31:0] PC, EPC;
  logic        flush_IF, irq_ack;
  int checks = 0;
  int failures = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .id_pc_plus_4(id_pc_plus_4), .jr(jr), .jr_target(jr_target),
    .exception(exception), .irq(irq), .PC(PC), .flush_IF(flush_IF),
    .irq_ack(irq_ack), .EPC(EPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        pend, stall, br;
    logic [31:0] br_t;
    logic        jmp;
    logic [25:0] jidx;
    logic [31:0] idpc4;
    logic        jr;
    logic [31:0] jrt;
    logic        exc, irq, e_flush;
    logic [31:0] e_pc, e_epc;
    logic        e_ack;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
    id_pc_plus_4 = 0; jr = 0; jr_target = 0; exception = 0; irq = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // steer PC to a known value through jr; irq_in optionally arms irq_pending
  task automatic set_pc(input logic [31:0] pc, input logic irq_in);
    clear_inputs();
    jr = 1; jr_target = pc; irq = irq_in;
    tick();
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            start          pend st br br_t           jmp jidx          idpc4          jr jrt            exc irq fl pc             epc            ack
    vecs[0]  = '{32'h0000_0100, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 0, 32'h0000_0104, 32'h0,         0};
    vecs[1]  = '{32'h0000_0010, 0, 0, 0, 32'h0,         1, 26'h40,       32'h0000_000C, 0, 32'h0,         0, 0, 1, 32'h0000_0100, 32'h0,         0};
    vecs[2]  = '{32'h0000_0020, 0, 1, 0, 32'h0,         1, 26'h40,       32'h0000_0024, 0, 32'h0,         0, 0, 0, 32'h0000_0020, 32'h0,         0};
    vecs[3]  = '{32'h0000_0030, 0, 1, 1, 32'h0000_0200, 0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 1, 32'h0000_0200, 32'h0,         0};
    vecs[4]  = '{32'h0000_0060, 0, 0, 1, 32'h0000_0300, 1, 26'h40,       32'h0000_0064, 0, 32'h0,         0, 0, 1, 32'h0000_0300, 32'h0,         0};
    vecs[5]  = '{32'h0000_0070, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         1, 32'h0000_1233, 0, 0, 1, 32'h0000_1233, 32'h0,         0};
    vecs[6]  = '{32'h0000_0070, 0, 0, 0, 32'h0,         1, 26'h40,       32'h0000_0074, 1, 32'h0000_0500, 0, 0, 1, 32'h0000_0500, 32'h0,         0};
    vecs[7]  = '{32'h0000_0080, 0, 1, 0, 32'h0,         0, 26'h0,        32'h0000_007C, 0, 32'h0,         1, 0, 1, EXC_VEC,       32'h0000_0078, 0};
    vecs[8]  = '{32'h0000_0040, 1, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 1, IRQ_VEC,       32'h0000_0044, 1};
    vecs[9]  = '{32'h8000_0100, 1, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 0, 32'h8000_0104, 32'h0,         0};
    vecs[10] = '{32'h0000_0040, 1, 1, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 0, 32'h0000_0040, 32'h0,         0};
    vecs[11] = '{32'h0000_0040, 1, 0, 0, 32'h0,         1, 26'h10,       32'h0000_0044, 0, 32'h0,         0, 0, 1, 32'h0000_0040, 32'h0,         0};
    vecs[12] = '{32'hFFFF_FFFC, 0, 0, 0, 32'h0,         0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 0, 32'h0000_0000, 32'h0,         0};
    vecs[13] = '{32'h0000_0090, 0, 0, 1, 32'h0000_0300, 0, 26'h0,        32'h0000_0090, 0, 32'h0,         1, 0, 1, EXC_VEC,       32'h0000_008C, 0};
    vecs[14] = '{32'h0000_0040, 1, 0, 1, 32'h0000_0600, 0, 26'h0,        32'h0,         0, 32'h0,         0, 0, 1, 32'h0000_0600, 32'h0,         0};
    vecs[15] = '{32'h0000_0010, 0, 0, 0, 32'h0,         1, 26'h3FF_FFFF, 32'hA000_0010, 0, 32'h0,         0, 0, 1, 32'hAFFF_FFFC, 32'h0,         0};

    clear_inputs();
    reset = 1;
    stall = 1; exception = 1; irq = 1; jump = 1;
    #1;
    check("flush_during_reset", {31'd0, flush_IF}, 32'd0);
    tick();
    tick();
    check("reset_pc", PC, 32'h0);
    check("reset_epc", EPC, 32'h0);
    check("reset_ack", {31'd0, irq_ack}, 32'd0);
    clear_inputs();
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("seq_pc_%0d", i), PC, 32'(4 * i));
    end
    check("seq_no_pending_after_reset_irq", {31'd0, irq_ack}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_reset();
      set_pc(vecs[i].start_pc, vecs[i].pend);
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].br_t;
      jump = vecs[i].jmp; jump_index = vecs[i].jidx; id_pc_plus_4 = vecs[i].idpc4;
      jr = vecs[i].jr; jr_target = vecs[i].jrt; exception = vecs[i].exc; irq = vecs[i].irq;
      #1;
      check($sformatf("v%0d_flush", i), {31'd0, flush_IF}, {31'd0, vecs[i].e_flush});
      tick();
      check($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      check($sformatf("v%0d_epc", i), EPC, vecs[i].e_epc);
      check($sformatf("v%0d_ack", i), {31'd0, irq_ack}, {31'd0, vecs[i].e_ack});
    end

    // stalled jump held two cycles, then taken once stall drops
    do_reset();
    set_pc(32'h20, 0);
    for (int i = 0; i < 2; i++) begin
      stall = 1; jump = 1; jump_index = 26'h100; id_pc_plus_4 = 32'h24;
      #1;
      check("stall_jump_flush", {31'd0, flush_IF}, 32'd0);
      tick();
      check("stall_jump_hold", PC, 32'h20);
    end
    stall = 0;
    #1;
    check("unstall_jump_flush", {31'd0, flush_IF}, 32'd1);
    tick();
    check("unstall_jump_pc", PC, 32'h400);

    // interrupt take, then a second irq masked in kernel mode until return
    do_reset();
    set_pc(32'h40, 1);
    #1;
    check("irq_take_flush", {31'd0, flush_IF}, 32'd1);
    tick();
    check("irq_take_pc", PC, IRQ_VEC);
    check("irq_take_epc", EPC, 32'h44);
    check("irq_take_ack", {31'd0, irq_ack}, 32'd1);
    tick();
    check("irq_ack_one_cycle", {31'd0, irq_ack}, 32'd0);
    check("irq_handler_pc", PC, 32'h8000_0008);
    irq = 1;
    tick();
    irq = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("kernel_masked_ack", {31'd0, irq_ack}, 32'd0);
    end
    check("kernel_masked_pc", PC, 32'h8000_0018);
    set_pc(32'h100, 0);
    check("return_pc", PC, 32'h100);
    tick();
    check("pending_taken_pc", PC, IRQ_VEC);
    check("pending_taken_epc", EPC, 32'h104);
    check("pending_taken_ack", {31'd0, irq_ack}, 32'd1);

    // exception beats a simultaneous irq; the irq stays pending
    do_reset();
    set_pc(32'h50, 0);
    exception = 1; irq = 1; id_pc_plus_4 = 32'h54;
    tick();
    clear_inputs();
    check("exc_irq_pc", PC, EXC_VEC);
    check("exc_irq_epc", EPC, 32'h50);
    check("exc_irq_ack", {31'd0, irq_ack}, 32'd0);
    set_pc(32'h200, 0);
    tick();
    check("exc_irq_pending_pc", PC, IRQ_VEC);
    check("exc_irq_pending_epc", EPC, 32'h204);

    // reset discards a pending interrupt
    do_reset();
    set_pc(32'h8000_0000, 1);
    do_reset();
    check("reset_discard_pc0", PC, 32'h0);
    tick();
    check("reset_discard_pc", PC, 32'h4);
    check("reset_discard_ack", {31'd0, irq_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 Parameter IRQ_VEC, 32'h80000004, interrupt handler entry.
REQ-003 Parameter EXC_VEC, 32'h80000008, exception handler entry.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  load-use hazard hold from ID; freeze PC.
REQ-007 branch_taken  input  1  EX-stage branch resolved taken.
REQ-008 branch_target  input  32  EX-stage branch destination.
REQ-009 jump  input  1  ID-stage j/jal decoded.
REQ-010 jump_index  input  26  instruction[25:0] of the ID-stage jump.
REQ-011 id_pc_plus_4  input  32  PC+4 of the instruction in ID.
REQ-012 jr  input  1  ID-stage jr/jalr decoded.
REQ-013 jr_target  input  32  forwarded rs value.
REQ-014 exception  input  1  undefined-instruction trap from ID.
REQ-015 irq  input  1  external interrupt request, level.
REQ-016 PC  output  32  registered fetch address driven to the fetch stage.
REQ-017 flush_IF  output  1  combinational; fetched instruction must be squashed this cycle.
REQ-018 irq_ack  output  1  registered one-cycle pulse when interrupt vector is taken.
REQ-019 EPC  output  32  registered return address of the last interrupt/exception.

Function
REQ-020 PC update priority per cycle, highest first: exception, branch_taken, irq-take, jr, jump, stall hold, PC+4.
REQ-021 exception: PC <= EXC_VEC; EPC <= id_pc_plus_4 - 4; overrides stall.
REQ-022 branch_taken: PC <= branch_target; overrides stall.
REQ-023 jr/jump ignored while stall=1 (instruction still in ID, re-presented next cycle).
REQ-024 jr: PC <= jr_target, no alignment correction.
REQ-025 jump: PC <= {id_pc_plus_4[31:28], jump_index, 2'b00}.
REQ-026 stall with no higher-priority event: PC, EPC, irq_pending unchanged except irq latch.
REQ-027 Default: PC <= PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-028 irq_pending flop set on any cycle irq=1; cleared only when interrupt taken or reset.
REQ-029 Interrupt taken when irq_pending=1, PC[31]=0, stall=0, and no exception/branch_taken/jr/jump that cycle.
REQ-030 Interrupt take: PC <= IRQ_VEC; EPC <= PC + 4; irq_pending <= 0; irq_ack <= 1 next cycle only.
REQ-031 PC[31]=1 (kernel mode) masks interrupt; pending retained until PC[31]=0.
REQ-032 flush_IF = exception | branch_taken | interrupt-take | ((jr|jump) & ~stall).
REQ-033 Simultaneous irq and exception: exception wins, irq_pending stays set.
REQ-034 Simultaneous branch_taken and jump: branch target used; jump dropped (it is on the wrong path).

Reset
REQ-035 reset=1 at a rising edge: PC <= RESET_PC, EPC <= 0, irq_pending <= 0, irq_ack <= 0; overrides all inputs.
REQ-036 Reset mid-stall or with irq pending discards all pending state; first post-reset fetch is RESET_PC.
REQ-037 flush_IF is 0 while reset is asserted.

Verification
REQ-038 Reset released, no events, 3 cycles -> PC = 0x0, 0x4, 0x8, 0xC.
REQ-039 PC=0x10, jump=1, jump_index=0x0000040, id_pc_plus_4=0x0C -> flush_IF=1, next PC=0x00000100.
REQ-040 stall=1 with jump=1 for 2 cycles at PC=0x20 -> PC holds 0x20, flush_IF=0; stall drops -> PC=jump target.
REQ-041 stall=1, branch_taken=1, branch_target=0x200 -> flush_IF=1, next PC=0x200.
REQ-042 irq pulse at PC=0x40, stall=0 -> next PC=0x80000004, EPC=0x44, irq_ack pulse 1 cycle; second irq in kernel mode held pending until PC[31]=0.
REQ-043 exception and irq same cycle, id_pc_plus_4=0x54 -> PC=0x80000008, EPC=0x50, irq_pending remains 1.
